// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: a free-running cycle counter, per-event counters with
// sticky overflow flags, and a FIFO that records the PC of every branch-hazard flush.
module pipe_perf_monitor #(
    parameter int NUM_EVENTS  = 4,
    parameter int CNT_W       = 64,
    parameter int TRACE_DEPTH = 8,
    parameter int PC_W        = 32,
    parameter int SATURATE    = 0,
    localparam int SEL_W      = $clog2(NUM_EVENTS + 1),
    localparam int TCNT_W     = $clog2(TRACE_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [NUM_EVENTS-1:0] event_in,
    input  logic                  flush_valid,
    input  logic [PC_W-1:0]       flush_pc,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_W-1:0]      rd_data,
    output logic [NUM_EVENTS:0]   ovf,
    output logic                  trace_valid,
    output logic [PC_W-1:0]       trace_pc,
    input  logic                  trace_ready,
    output logic [TCNT_W-1:0]     trace_count,
    output logic                  trace_dropped
);

    localparam int NCNT  = NUM_EVENTS + 1;
    localparam int PTR_W = $clog2(TRACE_DEPTH);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [TCNT_W-1:0] TCNT_ZERO = {TCNT_W{1'b0}};
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1'b1);
    localparam logic [TCNT_W-1:0] TCNT_FULL = TCNT_W'(TRACE_DEPTH);
    localparam logic [PC_W-1:0]   PC_ZERO   = {PC_W{1'b0}};

    // Index 0 is the cycle counter, index k is event channel k-1.
    logic [CNT_W-1:0]  cnt_r     [NCNT];
    logic [CNT_W-1:0]  cnt_nxt_s [NCNT];
    logic [NCNT-1:0]   inc_s;
    logic [NCNT-1:0]   ovf_r;
    logic [NCNT-1:0]   ovf_nxt_s;
    logic [CNT_W-1:0]  rd_mux_s;
    logic [CNT_W-1:0]  rd_data_r;

    logic [PC_W-1:0]   mem_r [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [TCNT_W-1:0] count_r;
    logic [TCNT_W-1:0] count_nxt_s;
    logic              valid_r;
    logic              dropped_r;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;

    assign rd_data       = rd_data_r;
    assign ovf           = ovf_r;
    assign trace_valid   = valid_r;
    assign trace_pc      = mem_r[rd_ptr_r];
    assign trace_count   = count_r;
    assign trace_dropped = dropped_r;

    // Per-counter increment request: the cycle counter always counts while enabled.
    always_comb begin
        inc_s = {event_in, 1'b1} & {NCNT{enable}};
    end

    // Next counter values and overflow flags, wrapping or saturating at all-ones.
    always_comb begin
        for (int i = 0; i < NCNT; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            ovf_nxt_s[i] = ovf_r[i];
            if (inc_s[i]) begin
                if (&cnt_r[i]) begin
                    ovf_nxt_s[i] = 1'b1;
                    if (SATURATE != 0) begin
                        cnt_nxt_s[i] = cnt_r[i];
                    end else begin
                        cnt_nxt_s[i] = CNT_ZERO;
                    end
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Read-back mux; selects beyond the last channel read as zero.
    always_comb begin
        rd_mux_s = CNT_ZERO;
        for (int i = 0; i < NCNT; i++) begin
            rd_mux_s = (rd_sel == SEL_W'(i)) ? cnt_r[i] : rd_mux_s;
        end
    end

    // Counter and overflow state; clear wins over any increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            ovf_r <= {NCNT{1'b0}};
        end else if (clear) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            ovf_r <= {NCNT{1'b0}};
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            ovf_r <= ovf_nxt_s;
        end
    end

    // Registered read port samples the pre-update counter value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_r <= CNT_ZERO;
        end else begin
            rd_data_r <= rd_mux_s;
        end
    end

    // FIFO handshake: a pop frees the slot a same-cycle push on a full FIFO needs.
    always_comb begin
        full_s      = (count_r == TCNT_FULL);
        pop_s       = valid_r & trace_ready;
        push_s      = enable & flush_valid & (~full_s | pop_s);
        drop_s      = enable & flush_valid & full_s & ~pop_s;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + TCNT_ONE;
            2'b01:   count_nxt_s = count_r - TCNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Flush-trace FIFO storage, pointers, occupancy and drop flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                mem_r[i] <= PC_ZERO;
            end
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            count_r   <= TCNT_ZERO;
            valid_r   <= 1'b0;
            dropped_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r  <= PTR_ZERO;
            rd_ptr_r  <= PTR_ZERO;
            count_r   <= TCNT_ZERO;
            valid_r   <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= flush_pc;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r   <= count_nxt_s;
            valid_r   <= (count_nxt_s != TCNT_ZERO);
            dropped_r <= dropped_r | drop_s;
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: a reference model predicts counters and FIFO,
// expected read-back values are queued at drive time and popped when the DUT answers.
module tb_pipe_perf_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [3:0]  event_in;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [2:0]  rd_sel;
    logic        trace_ready;

    logic [63:0] rd_data;
    logic [4:0]  ovf;
    logic        tv;
    logic [31:0] tpc;
    logic [3:0]  tc;
    logic        td;

    logic [3:0]  rd_w, rd_s;
    logic [4:0]  ovf_w, ovf_s;
    logic        tv_w, tv_s, td_w, td_s;
    logic [31:0] tpc_w, tpc_s;
    logic [3:0]  tc_w, tc_s;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] m_cnt [5];
    logic [31:0] m_q [$];
    logic        m_drop;
    logic [63:0] rd_q [$];

    always #5 clock = ~clock;

    pipe_perf_monitor dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .event_in(event_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf), .trace_valid(tv),
        .trace_pc(tpc), .trace_ready(trace_ready), .trace_count(tc), .trace_dropped(td)
    );

    pipe_perf_monitor #(.CNT_W(4), .SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .event_in(event_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .rd_sel(rd_sel), .rd_data(rd_w), .ovf(ovf_w), .trace_valid(tv_w),
        .trace_pc(tpc_w), .trace_ready(trace_ready), .trace_count(tc_w), .trace_dropped(td_w)
    );

    pipe_perf_monitor #(.CNT_W(4), .SATURATE(1)) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .event_in(event_in), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .rd_sel(rd_sel), .rd_data(rd_s), .ovf(ovf_s), .trace_valid(tv_s),
        .trace_pc(tpc_s), .trace_ready(trace_ready), .trace_count(tc_s), .trace_dropped(td_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_cnt[i] = 64'd0;
        m_q.delete();
        m_drop = 1'b0;
        rd_q.delete();
    endtask

    // One clock: predict, apply the edge, then compare against the main DUT.
    task automatic step();
        logic        pop;
        logic        full;
        logic [63:0] exp_rd;
        if (rd_sel <= 3'd4) exp_rd = m_cnt[int'(rd_sel)];
        else exp_rd = 64'd0;
        rd_q.push_back(exp_rd);
        pop  = (m_q.size() != 0) && trace_ready;
        full = (m_q.size() == 8);
        if (clear) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 64'd0;
            m_q.delete();
            m_drop = 1'b0;
        end else begin
            if (enable) begin
                m_cnt[0] = m_cnt[0] + 64'd1;
                for (int k = 0; k < 4; k++)
                    if (event_in[k]) m_cnt[k+1] = m_cnt[k+1] + 64'd1;
            end
            if (pop) void'(m_q.pop_front());
            if (enable && flush_valid) begin
                if (!full || pop) m_q.push_back(flush_pc);
                else m_drop = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check("rd_data", rd_data, rd_q.pop_front());
        check("ovf", 64'(ovf), 64'd0);
        check("trace_count", 64'(tc), 64'(m_q.size()));
        check("trace_valid", 64'(tv), 64'(m_q.size() != 0));
        check("trace_dropped", 64'(td), 64'(m_drop));
        if (m_q.size() != 0) check("trace_pc", 64'(tpc), 64'(m_q[0]));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; event_in = 4'd0;
        flush_valid = 1'b0; flush_pc = 32'd0; rd_sel = 3'd0; trace_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_rd_data", rd_data, 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_count", 64'(tc), 64'd0);
        check("rst_valid", 64'(tv), 64'd0);
        check("rst_dropped", 64'(td), 64'd0);
        check("rst_pc", 64'(tpc), 64'd0);
        reset = 1'b0;

        // 4-bit counters: 17 enabled cycles, wrap versus saturate.
        enable = 1'b1;
        repeat (17) step();
        enable = 1'b0;
        step();
        check("wrap_rd", 64'(rd_w), 64'd1);
        check("wrap_ovf0", 64'(ovf_w[0]), 64'd1);
        check("sat_rd", 64'(rd_s), 64'd15);
        check("sat_ovf0", 64'(ovf_s[0]), 64'd1);
        check("wide_rd", rd_data, 64'd17);

        // Cycle and event counting after a clear.
        clear = 1'b1;
        step();
        clear = 1'b0;
        enable = 1'b1;
        event_in = 4'b0001;
        repeat (3) step();
        event_in = 4'b0000;
        repeat (7) step();
        enable = 1'b0;
        rd_sel = 3'd0;
        step();
        check("cyc_10", rd_data, 64'd10);
        rd_sel = 3'd1;
        step();
        check("ev0_3", rd_data, 64'd3);
        enable = 1'b1;
        event_in = 4'b1010;
        repeat (4) step();
        enable = 1'b0;
        event_in = 4'b0000;
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            step();
        end

        // Overfill the FIFO with trace_ready low, then drain with enable low.
        enable = 1'b1;
        trace_ready = 1'b0;
        flush_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            flush_pc = 32'h100 + 32'(i * 4);
            step();
        end
        check("fill_count", 64'(tc), 64'd8);
        check("fill_dropped", 64'(td), 64'd1);
        flush_valid = 1'b0;
        enable = 1'b0;
        trace_ready = 1'b1;
        repeat (8) step();

        // Full FIFO with push and pop together.
        enable = 1'b1;
        trace_ready = 1'b0;
        flush_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            flush_pc = 32'h200 + 32'(i * 4);
            step();
        end
        trace_ready = 1'b1;
        flush_pc = 32'h300;
        step();
        check("pushpop_count", 64'(tc), 64'd8);
        flush_valid = 1'b0;
        enable = 1'b0;
        repeat (7) step();
        check("last_pc", 64'(tpc), 64'h300);
        step();

        // Clear beats simultaneous events and flush.
        enable = 1'b1;
        trace_ready = 1'b0;
        flush_valid = 1'b1;
        flush_pc = 32'h400;
        repeat (3) step();
        clear = 1'b1;
        event_in = 4'hF;
        trace_ready = 1'b1;
        step();
        check("clr_valid", 64'(tv), 64'd0);
        check("clr_ovf_w", 64'(ovf_w), 64'd0);
        clear = 1'b0;
        enable = 1'b0;
        flush_valid = 1'b0;
        event_in = 4'd0;
        for (int s = 0; s < 5; s++) begin
            rd_sel = 3'(s);
            step();
        end

        // Mixed traffic.
        for (int n = 0; n < 40; n++) begin
            enable = 1'($urandom_range(0, 1));
            event_in = 4'($urandom);
            flush_valid = 1'($urandom_range(0, 1));
            flush_pc = $urandom;
            trace_ready = ($urandom_range(0, 3) == 0);
            rd_sel = 3'($urandom);
            step();
        end

        // Asynchronous reset between edges.
        enable = 1'b1;
        event_in = 4'hF;
        trace_ready = 1'b0;
        flush_valid = 1'b1;
        flush_pc = 32'h500;
        rd_sel = 3'd0;
        repeat (10) step();
        #2;
        reset = 1'b1;
        #1;
        check("arst_rd_data", rd_data, 64'd0);
        check("arst_ovf", 64'(ovf), 64'd0);
        check("arst_count", 64'(tc), 64'd0);
        check("arst_valid", 64'(tv), 64'd0);
        check("arst_dropped", 64'(td), 64'd0);
        check("arst_pc", 64'(tpc), 64'd0);
        check("arst_ovf_w", 64'(ovf_w), 64'd0);
        check("arst_rd_s", 64'(rd_s), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        event_in = 4'd0;
        flush_valid = 1'b0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        check("post_rst_cyc", rd_data, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
